// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared constants for the hazard unit: the operand forwarding source encodings
//   and the helper that sizes register-index fields from the register count.
package hazard_pkg;

    localparam logic [2:0] FWD_NONE    = 3'b000;
    localparam logic [2:0] FWD_EXE     = 3'b001;
    localparam logic [2:0] FWD_MEM_ALU = 3'b010;
    localparam logic [2:0] FWD_MEM_LD  = 3'b011;
    localparam logic [2:0] FWD_MCU     = 3'b100;

    // Index width for a register file of n entries; a single-entry file still
    // needs a 1-bit index so that port widths never collapse to zero.
    function automatic int reg_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hazard_unit_mc_if.sv
// hazard_unit_mc_if
//   Bundle of every ID/EXE/MEM/MCU signal exchanged between the pipeline and
//   the hazard unit. clk and rst are kept as plain ports on the modules.
//   Modports:
//     master - pipeline side: drives stage info and MCU status, receives controls
//     slave  - hazard unit side: receives stage info, drives controls/forward selects
interface hazard_unit_mc_if
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32
);
    localparam int REG_AW = reg_aw(NUM_REGS);

    logic              Branch_ID, rs1use_ID, rs2use_ID, mcu_issue_ID;
    logic [REG_AW-1:0] rs1_ID, rs2_ID, rd_ID, rd_EXE, rd_MEM, rs2_EXE;
    logic              mem_w_EXE, DatatoReg_EXE, RegWrite_EXE, DatatoReg_MEM, RegWrite_MEM;
    logic              mcu_done;
    logic [REG_AW-1:0] mcu_rd;

    logic              PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush;
    logic              reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN;
    logic [2:0]        forward_ctrl_A, forward_ctrl_B;
    logic              forward_ctrl_ls, mcu_issue_ok, mcu_err;

    modport master (
        output Branch_ID, rs1use_ID, rs2use_ID, mcu_issue_ID,
               rs1_ID, rs2_ID, rd_ID, rd_EXE, rd_MEM, rs2_EXE,
               mem_w_EXE, DatatoReg_EXE, RegWrite_EXE, DatatoReg_MEM, RegWrite_MEM,
               mcu_done, mcu_rd,
        input  PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush,
               reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN,
               forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, mcu_issue_ok, mcu_err
    );

    modport slave (
        input  Branch_ID, rs1use_ID, rs2use_ID, mcu_issue_ID,
               rs1_ID, rs2_ID, rd_ID, rd_EXE, rd_MEM, rs2_EXE,
               mem_w_EXE, DatatoReg_EXE, RegWrite_EXE, DatatoReg_MEM, RegWrite_MEM,
               mcu_done, mcu_rd,
        output PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush,
               reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN,
               forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, mcu_issue_ok, mcu_err
    );

endinterface

// File: rtl/hazard_unit_mc_reg_scoreboard.sv
// reg_scoreboard
//   Tracks which architectural registers are waiting on the multi-cycle unit,
//   whether an MCU op is outstanding, and how long it has been outstanding.
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     set_req, set_idx   an MCU op was accepted and will write set_idx
//     clr_req, clr_idx   the outstanding MCU op completed, writing clr_idx
//     busy               per-register pending-write vector (bit 0 never set)
//     pending            an MCU op is outstanding
//     mcu_err            sticky: an op stayed outstanding MCU_TIMEOUT cycles
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int MCU_TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        set_req,
    input  logic [reg_aw(NUM_REGS)-1:0] set_idx,
    input  logic                        clr_req,
    input  logic [reg_aw(NUM_REGS)-1:0] clr_idx,
    output logic [NUM_REGS-1:0]         busy,
    output logic                        pending,
    output logic                        mcu_err
);
    localparam int               AGE_W   = $clog2(MCU_TIMEOUT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MCU_TIMEOUT);

    logic [NUM_REGS-1:0] busy_d, busy_q;
    logic                pending_d, pending_q;
    logic [AGE_W-1:0]    age_d, age_q;
    logic                err_d, err_q;

    // Clear is applied before set so a completion and a new issue to the same
    // register in one cycle leaves the register busy for the new op.
    always_comb begin
        busy_d = busy_q;
        if (clr_req) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_req && set_idx != '0) begin
            busy_d[set_idx] = 1'b1;
        end

        pending_d = pending_q;
        if (set_req) begin
            pending_d = 1'b1;
        end else if (clr_req) begin
            pending_d = 1'b0;
        end

        // Age restarts with every issue or completion and saturates at the
        // timeout so the error comparison cannot wrap around.
        age_d = age_q;
        if (set_req || clr_req) begin
            age_d = '0;
        end else if (pending_q && age_q != AGE_MAX) begin
            age_d = age_q + 1'b1;
        end

        err_d = err_q || (age_d == AGE_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            pending_q <= 1'b0;
            age_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
            age_q     <= age_d;
            err_q     <= err_d;
        end
    end

    assign busy    = busy_q;
    assign pending = pending_q;
    assign mcu_err = err_q;

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
//   Hazard controller for the 5-stage core with a scoreboard for one
//   variable-latency multi-cycle unit (mul/div). Produces operand forwarding
//   selects, the load-to-store forward, and PC/IF-ID/ID-EX stall and flush
//   controls for load-use, MCU RAW/WAW/structural hazards and taken branches.
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     hz          hazard_unit_mc_if.slave: stage info in, pipeline controls out
//     stall_cnt   (HAZ_PERF_CNT_EN only) saturating count of PC-stalled cycles
//     flush_cnt   (HAZ_PERF_CNT_EN only) saturating count of IF/ID flush cycles
//   Configuration:
//     HAZ_PERF_CNT_EN  defined: adds PERF_W parameter and the two counter ports
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int MCU_TIMEOUT = 64
`ifdef HAZ_PERF_CNT_EN
    ,parameter int PERF_W     = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    hazard_unit_mc_if.slave   hz
`ifdef HAZ_PERF_CNT_EN
    ,output logic [PERF_W-1:0] stall_cnt
    ,output logic [PERF_W-1:0] flush_cnt
`endif
);
    localparam int REG_AW = reg_aw(NUM_REGS);

    logic [NUM_REGS-1:0] busy, busy_eff;
    logic                mcu_pending, mcu_err_w, done_ok;
    logic                stall_lu, stall_sb, stall;
    logic                pc_en, fd_stall, fd_flush, de_flush, issue_ok, fwd_ls;
    logic [2:0]          fwd_a, fwd_b;

    function automatic logic [2:0] fwd_sel(
        input logic [REG_AW-1:0] rs,     input logic rs_used,
        input logic rw_exe, input logic [REG_AW-1:0] rd_exe,
        input logic mcu_ok, input logic [REG_AW-1:0] mcu_rd,
        input logic rw_mem, input logic [REG_AW-1:0] rd_mem, input logic ld_mem);
        logic [2:0] sel;
        sel = FWD_NONE;
        if (rs_used && rs != '0) begin
            if (rw_exe && rd_exe == rs) begin
                sel = FWD_EXE;
            end else if (mcu_ok && mcu_rd == rs) begin
                sel = FWD_MCU;
            end else if (rw_mem && rd_mem == rs) begin
                sel = ld_mem ? FWD_MEM_LD : FWD_MEM_ALU;
            end
        end
        return sel;
    endfunction

    // A completion is only meaningful while an op is outstanding; a stray
    // mcu_done neither forwards nor clears anything.
    assign done_ok = hz.mcu_done && mcu_pending;

    // Registers completing this cycle are forwarded, so they no longer block.
    always_comb begin
        busy_eff = busy;
        if (done_ok) begin
            busy_eff[hz.mcu_rd] = 1'b0;
        end
    end

    assign stall_lu = hz.RegWrite_EXE && hz.DatatoReg_EXE &&
                      ((hz.rs1use_ID && hz.rs1_ID != '0 && hz.rs1_ID == hz.rd_EXE) ||
                       (hz.rs2use_ID && hz.rs2_ID != '0 && hz.rs2_ID == hz.rd_EXE));

    assign stall_sb = (hz.rs1use_ID && hz.rs1_ID != '0 && busy_eff[hz.rs1_ID]) ||
                      (hz.rs2use_ID && hz.rs2_ID != '0 && busy_eff[hz.rs2_ID]) ||
                      (hz.mcu_issue_ID && busy_eff[hz.rd_ID]) ||
                      (hz.mcu_issue_ID && mcu_pending && !done_ok);

    assign stall = stall_lu || stall_sb;

    // Stall beats branch: a stalled branch stays in ID and redirects next cycle.
    // While in reset every control sits at its pass-through value.
    always_comb begin
        pc_en    = 1'b1;
        fd_stall = 1'b0;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        issue_ok = 1'b0;
        fwd_ls   = 1'b0;
        fwd_a    = FWD_NONE;
        fwd_b    = FWD_NONE;
        if (!rst) begin
            fwd_a  = fwd_sel(hz.rs1_ID, hz.rs1use_ID, hz.RegWrite_EXE, hz.rd_EXE, done_ok,
                             hz.mcu_rd, hz.RegWrite_MEM, hz.rd_MEM, hz.DatatoReg_MEM);
            fwd_b  = fwd_sel(hz.rs2_ID, hz.rs2use_ID, hz.RegWrite_EXE, hz.rd_EXE, done_ok,
                             hz.mcu_rd, hz.RegWrite_MEM, hz.rd_MEM, hz.DatatoReg_MEM);
            fwd_ls = hz.mem_w_EXE && hz.RegWrite_MEM && hz.DatatoReg_MEM &&
                     hz.rd_MEM == hz.rs2_EXE && hz.rd_MEM != '0;
            if (stall) begin
                pc_en    = 1'b0;
                fd_stall = 1'b1;
                de_flush = 1'b1;
            end else if (hz.Branch_ID) begin
                fd_flush = 1'b1;
            end
            issue_ok = hz.mcu_issue_ID && !stall;
        end
    end

    reg_scoreboard #(
        .NUM_REGS    (NUM_REGS),
        .MCU_TIMEOUT (MCU_TIMEOUT)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_req (issue_ok),
        .set_idx (hz.rd_ID),
        .clr_req (done_ok),
        .clr_idx (hz.mcu_rd),
        .busy    (busy),
        .pending (mcu_pending),
        .mcu_err (mcu_err_w)
    );

    assign hz.PC_EN_IF        = pc_en;
    assign hz.reg_FD_EN       = 1'b1;
    assign hz.reg_FD_stall    = fd_stall;
    assign hz.reg_FD_flush    = fd_flush;
    assign hz.reg_DE_EN       = 1'b1;
    assign hz.reg_DE_flush    = de_flush;
    assign hz.reg_EM_EN       = 1'b1;
    assign hz.reg_EM_flush    = 1'b0;
    assign hz.reg_MW_EN       = 1'b1;
    assign hz.forward_ctrl_A  = fwd_a;
    assign hz.forward_ctrl_B  = fwd_b;
    assign hz.forward_ctrl_ls = fwd_ls;
    assign hz.mcu_issue_ok    = issue_ok;
    assign hz.mcu_err         = mcu_err_w;

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (fd_flush && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
